mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch path (PC address) and the EX-stage load/store path (memRead_ex/memWrite_ex).
- Serialises the two requesters onto one req/ack memory interface.
- Returns read data and a one-cycle completion pulse to each requester.
- Drives per-requester stall flags so the pipeline holds while its access is outstanding.
- Sits between the riscv core top and the external memory model.

Parameters:
N, 32, data/address width
MAX_DATA_BURST, 4, consecutive data grants allowed while a fetch waits before fetch is forced through (>=1)

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-high
if_req  in  1  fetch request; held until if_valid
if_addr  in  N  fetch address; stable while if_req
if_rdata  out  N  fetched instruction
if_valid  out  1  one-cycle fetch completion pulse
d_req  in  1  data request (load or store); held until d_valid
d_we  in  1  1=store, 0=load; stable while d_req
d_addr  in  N  data address; stable while d_req
d_wdata  in  N  store data; stable while d_req
d_rdata  out  N  load data
d_valid  out  1  one-cycle data completion pulse
if_stall  out  1  if_req & ~if_valid (combinational)
d_stall  out  1  d_req & ~d_valid (combinational)
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  N  memory address, registered
mem_wdata  out  N  memory write data, registered
mem_ack  in  1  memory completion; may arrive any cycle >=0 after mem_req rises
mem_rdata  in  N  read data, valid with mem_ack

Behaviour:
- Clocking/reset: one clock (clk); reset (rstn) is synchronous and active-high.
- Reset values: state IDLE; all outputs 0, including if_rdata, d_rdata and burst counter.
- Reset mid-transaction: the transaction is abandoned; mem_req drops the next edge; no valid pulse is issued; a late mem_ack in IDLE is ignored.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE: evaluate eligible requests. A requester is ineligible in the cycle its own valid is high; this prevents a held req re-issuing.
  - Grant D if d_req is eligible, unless if_req is eligible and burst_cnt==MAX_DATA_BURST.
  - Otherwise grant I if if_req is eligible.
  - On grant: at the edge, load mem_req=1, mem_addr, mem_we (d_we for D, 0 for I) and mem_wdata (d_wdata for D, 0 for I); go to BUSY_x.
- BUSY_x: hold mem_* constant until mem_ack is sampled high. At that edge:
  - mem_req<=0; go to IDLE.
  - Pulse x_valid for exactly one cycle.
  - Load x_rdata<=mem_rdata on reads. d_rdata holds its previous value on stores.
- Latency: with zero-wait memory (ack in first mem_req cycle), req sampled at edge k gives mem_req during cycle k..k+1 and valid during cycle k+1..k+2. That is a 2-cycle request-to-valid latency.
- Throughput: each transaction costs at least 2 cycles. The valid/IDLE cycle may grant the other requester in the same cycle.
- burst_cnt (width clog2(MAX_DATA_BURST+1)):
  - On a D grant while if_req is pending: increment, saturating at MAX_DATA_BURST.
  - On an I grant, or a D grant with if_req low: clear to 0.
- Simultaneous if_req and d_req in IDLE: D wins, except when the burst limit has been reached.
- Requester protocol violations (req dropped or fields changed before valid) are not detected. The latched mem_* values are used regardless.
- mem_ack while in IDLE is ignored.

Test Plan:
1. Reset, then fetch only. if_req=1, if_addr=0x100, memory acks on the first mem_req cycle with 0x00500093. Required: mem_req=1, mem_we=0, mem_addr=0x100; if_valid is high exactly 2 cycles after req; if_rdata=0x00500093; d_valid stays 0.
2. Simultaneous requests. if_req (0x104) and d_req load (0x2000) both rise in the same cycle. Required: the data access is issued first; d_valid and d_rdata=mem_rdata; fetch of 0x104 is issued in d_valid's cycle; if_stall stays high until if_valid.
3. Store with wait states. d_req=1, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, ack delayed 3 cycles. Required: mem_* stable for 4 cycles; d_valid one pulse; d_rdata unchanged.
4. Starvation guard, MAX_DATA_BURST=4. d_req held continuously with if_req pending. Required: exactly 4 data grants, then 1 fetch grant, then data again; burst_cnt returns to 0 after the fetch grant.
5. Reset mid-BUSY_D. Assert rstn while waiting for ack, then ack 1 cycle later. Required: all outputs 0 after the reset edge; no d_valid pulse; the late ack is ignored; a fresh if_req is served normally afterwards.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : serialises instruction fetch and load/store onto one memory port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int N              = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic [N-1:0] if_rdata,
  output logic         if_valid,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  output logic [N-1:0] d_rdata,
  output logic         d_valid,
  output logic         if_stall,
  output logic         d_stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata
);

  localparam int            BW   = $clog2(MAX_DATA_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_DATA_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [N-1:0]  mem_addr_q, mem_addr_d;
  logic [N-1:0]  mem_wdata_q, mem_wdata_d;
  logic          if_valid_q, if_valid_d;
  logic          d_valid_q, d_valid_d;
  logic [N-1:0]  if_rdata_q, if_rdata_d;
  logic [N-1:0]  d_rdata_q, d_rdata_d;
  logic          if_elig, d_elig;

  // A requester whose completion is being pulsed this cycle must not be re-granted
  assign if_elig = if_req & ~if_valid_q;
  assign d_elig  = d_req & ~d_valid_q;

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (d_elig && !(if_elig && burst_q == BMAX)) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (!if_elig)
            burst_d = '0;
          else if (burst_q != BMAX)
            burst_d = burst_q + BW'(1);
        end else if (if_elig) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          burst_d     = '0;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_valid_d = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_valid_d = 1'b1;
          if (!mem_we_q)
            d_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign d_stall   = d_req & ~d_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed + randomized bench with a transaction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;
  localparam int N    = 32;
  localparam int MAXB = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic         if_req, d_req, d_we, mem_ack;
  logic [N-1:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [N-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic         if_valid, d_valid, if_stall, d_stall, mem_req, mem_we;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N(N), .MAX_DATA_BURST(MAXB)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .if_stall(if_stall), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int failures = 0;

  // Model: who owns the port (0 none, 1 fetch, 2 data) and the expected outputs
  int           e_owner, e_burst;
  logic         e_mem_req, e_we, e_if_valid, e_d_valid;
  logic [N-1:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;
  string        glog;

  // Memory responder
  int           mw = -1;
  int           next_wait = -1;
  bit           spur_en = 0;
  bit           rd_force = 0;
  logic [N-1:0] rd_val = '0;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=completion t=%0t", nm, $time);
  endtask

  task automatic model_clear();
    e_owner = 0; e_burst = 0; e_mem_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    e_if_valid = 0; e_d_valid = 0; e_if_rdata = '0; e_d_rdata = '0;
  endtask

  task automatic check_all();
    chk("mem_req", {31'd0, mem_req}, {31'd0, e_mem_req});
    chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("if_valid", {31'd0, if_valid}, {31'd0, e_if_valid});
    chk("d_valid", {31'd0, d_valid}, {31'd0, e_d_valid});
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
    chk("if_stall", {31'd0, if_stall}, {31'd0, if_req && !e_if_valid});
    chk("d_stall", {31'd0, d_stall}, {31'd0, d_req && !e_d_valid});
  endtask

  // Advance the model across one clock edge using the inputs currently applied
  task automatic model_step();
    bit ie, de;
    int win;
    if (rstn) begin
      model_clear();
      return;
    end
    ie = if_req && !e_if_valid;
    de = d_req && !e_d_valid;
    e_if_valid = 0;
    e_d_valid  = 0;
    if (e_owner == 0) begin
      win = 0;
      if (de && !(ie && e_burst == MAXB)) win = 2;
      else if (ie) win = 1;
      if (win == 2) begin
        e_burst = ie ? ((e_burst < MAXB) ? e_burst + 1 : MAXB) : 0;
        e_owner = 2; e_mem_req = 1; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata;
        glog = {glog, "D"};
      end else if (win == 1) begin
        e_burst = 0;
        e_owner = 1; e_mem_req = 1; e_we = 0; e_addr = if_addr; e_wdata = '0;
        glog = {glog, "I"};
      end
    end else if (mem_ack) begin
      if (e_owner == 1) begin
        e_if_valid = 1; e_if_rdata = mem_rdata;
      end else begin
        e_d_valid = 1;
        if (!e_we) e_d_rdata = mem_rdata;
      end
      e_owner = 0; e_mem_req = 0;
    end
  endtask

  task automatic mem_drive();
    if (!e_mem_req) begin
      mw = -1;
      mem_ack = spur_en && ($urandom_range(0, 3) == 0);
    end else begin
      if (mw < 0) mw = (next_wait >= 0) ? next_wait : $urandom_range(0, 3);
      else mw--;
      mem_ack = (mw == 0);
    end
    mem_rdata = (mem_ack && rd_force) ? rd_val : $urandom;
  endtask

  // Check at the falling edge, step the model, then respond just after the rising edge
  task automatic tick();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
    mem_drive();
  endtask

  task automatic wait_valid(input bit want_d, input string nm);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = want_d ? e_d_valid : e_if_valid;
    end
    if (!seen) timeout_fail(nm);
  endtask

  initial begin
    int n;
    logic [N-1:0] saved;
    rstn = 1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    glog = "";
    model_clear();
    @(posedge clk);
    #1;
    tick();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    rstn = 0;
    tick();

    // Fetch only, zero-wait memory
    if_req = 1; if_addr = 32'h100; next_wait = 0; rd_force = 1; rd_val = 32'h00500093;
    tick();
    chk("t1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    chk("t1_if_valid", {31'd0, if_valid}, 32'd1);
    chk("t1_if_rdata", if_rdata, 32'h00500093);
    chk("t1_d_valid", {31'd0, d_valid}, 32'd0);
    if_req = 0;
    tick();

    // Simultaneous fetch and load: data first, fetch issued from the data valid cycle
    if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h2000; rd_val = 32'h11223344;
    tick();
    chk("t2_first_addr", mem_addr, 32'h2000);
    chk("t2_if_stall_a", {31'd0, if_stall}, 32'd1);
    tick();
    chk("t2_d_valid", {31'd0, d_valid}, 32'd1);
    chk("t2_d_rdata", d_rdata, 32'h11223344);
    chk("t2_if_stall_b", {31'd0, if_stall}, 32'd1);
    d_req = 0; rd_val = 32'h00A00113;
    tick();
    chk("t2_fetch_addr", mem_addr, 32'h104);
    chk("t2_if_stall_c", {31'd0, if_stall}, 32'd1);
    tick();
    chk("t2_if_valid", {31'd0, if_valid}, 32'd1);
    chk("t2_if_rdata", if_rdata, 32'h00A00113);
    chk("t2_if_stall_d", {31'd0, if_stall}, 32'd0);
    if_req = 0;
    tick();

    // Store with three wait states
    rd_force = 0; next_wait = 3; saved = 32'h11223344;
    d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF;
    n = 0;
    for (int i = 0; i < 20 && !e_d_valid; i++) begin
      tick();
      if (mem_req === 1'b1 && mem_we === 1'b1 && mem_addr === 32'h2004 && mem_wdata === 32'hDEADBEEF)
        n++;
    end
    if (!e_d_valid) timeout_fail("t3_store_done");
    chk("t3_stable_cycles", n, 32'd4);
    chk("t3_d_valid", {31'd0, d_valid}, 32'd1);
    chk("t3_d_rdata_kept", d_rdata, saved);
    d_req = 0;
    tick();
    chk("t3_single_pulse", {31'd0, d_valid}, 32'd0);

    // Starvation guard: both requests raised together each round
    next_wait = 0; glog = "";
    for (int r = 0; r < 10; r++) begin
      if_req = 1; if_addr = 32'h400 + 4 * r;
      d_req = 1; d_we = 0; d_addr = 32'h3000 + 4 * r;
      tick();
      chk($sformatf("t4_grant_r%0d", r), mem_addr,
          (r == 4 || r == 9) ? 32'h400 + 4 * r : 32'h3000 + 4 * r);
      for (int i = 0; i < 10 && !(e_d_valid || e_if_valid); i++) tick();
      if (!(e_d_valid || e_if_valid)) timeout_fail("t4_round");
      if_req = 0; d_req = 0;
      tick();
    end
    chk("t4_model_log", {31'd0, glog == "DDDDIDDDDI"}, 32'd1);

    // Reset while a load waits for its ack, then a late ack
    next_wait = 10; rd_force = 1; rd_val = 32'h12345678;
    d_req = 1; d_we = 0; d_addr = 32'h2008;
    tick();
    tick();
    chk("t5_busy", {31'd0, mem_req}, 32'd1);
    rstn = 1; d_req = 0;
    tick();
    chk("t5_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t5_rst_mem_addr", mem_addr, 32'd0);
    chk("t5_rst_d_rdata", d_rdata, 32'd0);
    chk("t5_rst_if_rdata", if_rdata, 32'd0);
    rstn = 0; mem_ack = 1;
    tick();
    chk("t5_late_ack_req", {31'd0, mem_req}, 32'd0);
    chk("t5_late_ack_dv", {31'd0, d_valid}, 32'd0);
    next_wait = 1; if_req = 1; if_addr = 32'h300;
    wait_valid(0, "t5_fetch_done");
    chk("t5_if_rdata", if_rdata, 32'h12345678);
    if_req = 0;
    tick();

    // Randomized traffic, random waits, spurious idle acks, occasional resets
    spur_en = 1; next_wait = -1; rd_force = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rstn = ($urandom_range(0, 499) == 0);
      if (if_req) begin
        if (e_if_valid) begin
          if ($urandom_range(0, 3) != 0) if_req = 0;
          else if_addr = $urandom & 32'hFFFC;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom & 32'hFFFC;
      end
      if (d_req) begin
        if (e_d_valid) begin
          if ($urandom_range(0, 3) != 0) d_req = 0;
          else begin d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom; end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
      end
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
